// File: rtl/output_drain96.sv
// Result sink: captures one 3 x FP16 round per rise of output_ready96 into a small FIFO,
// then streams each neuron as an FP32 word over a valid/ready interface.
module output_drain96 #(
  parameter int DEPTH = 4
) (
  input  logic                     clk96,
  input  logic                     rstn96,
  input  logic                     output_ready96,
  input  logic [2:0][15:0]         outtie96,
  output logic                     out_valid96,
  input  logic                     out_ready96,
  output logic [31:0]              out_data96,
  output logic [1:0]               out_index96,
  output logic [12:0]              out_round96,
  output logic [$clog2(DEPTH):0]   level96,
  output logic                     overflow96
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  state_t state, state_nxt;

  logic [DEPTH-1:0][2:0][15:0] mem;
  logic [2:0][15:0]            hold;
  logic [AW-1:0]               wptr, rptr;
  logic                        prev_rdy;
  logic                        rise, full, push, pop, fire;
  logic [15:0]                 nxt_half;

  // Subnormals flush to signed zero; Inf/NaN keep their payload.
  function automatic logic [31:0] conv(input logic [15:0] h);
    case (h[14:10])
      5'd0:    conv = {h[15], 31'b0};
      5'd31:   conv = {h[15], 8'hFF, h[9:0], 13'b0};
      default: conv = {h[15], {3'b000, h[14:10]} + 8'd112, h[9:0], 13'b0};
    endcase
  endfunction

  assign rise = output_ready96 && !prev_rdy;
  assign full = (level96 == FULL_LVL);
  assign push = rise && !full;
  assign fire = out_valid96 && out_ready96;

  always_comb begin
    nxt_half = hold[2];
    if (out_index96 == 2'd0) nxt_half = hold[1];
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (level96 != '0) begin
        pop       = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: state_nxt = SEND;
      SEND: if (fire && out_index96 == 2'd2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage array carries no reset; pointers and level define what is live.
  always_ff @(posedge clk96) begin
    if (rstn96 && push) mem[wptr] <= outtie96;
  end

  always_ff @(posedge clk96) begin
    if (!rstn96) begin
      state       <= IDLE;
      prev_rdy    <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      level96     <= '0;
      overflow96  <= 1'b0;
      hold        <= '0;
      out_valid96 <= 1'b0;
      out_data96  <= '0;
      out_index96 <= '0;
      out_round96 <= '0;
    end else begin
      state    <= state_nxt;
      prev_rdy <= output_ready96;
      if (push) wptr <= wptr + 1'b1;
      if (rise && full) overflow96 <= 1'b1;
      if (pop) begin
        hold <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level96 <= level96 + 1'b1;
        2'b01:   level96 <= level96 - 1'b1;
        default: level96 <= level96;
      endcase
      case (state)
        LOAD: begin
          out_data96  <= conv(hold[0]);
          out_index96 <= 2'd0;
          out_valid96 <= 1'b1;
        end
        SEND: if (fire) begin
          if (out_index96 != 2'd2) begin
            out_data96  <= conv(nxt_half);
            out_index96 <= out_index96 + 2'd1;
          end else begin
            out_valid96 <= 1'b0;
            out_round96 <= out_round96 + 13'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_output_drain96.sv
// Self-checking bench for output_drain96: constant vector table, hand-written corner
// sequences, and a random phase checked against a transaction-level reference.
module tb_output_drain96;
  localparam int DEPTH = 4;

  logic             clk96 = 1'b0;
  logic             rstn96 = 1'b0;
  logic             output_ready96 = 1'b0;
  logic [2:0][15:0] outtie96 = '0;
  logic             out_valid96;
  logic             out_ready96 = 1'b0;
  logic [31:0]      out_data96;
  logic [1:0]       out_index96;
  logic [12:0]      out_round96;
  logic [2:0]       level96;
  logic             overflow96;

  always #5 clk96 = ~clk96;

  output_drain96 #(.DEPTH(DEPTH)) dut (
    .clk96(clk96), .rstn96(rstn96), .output_ready96(output_ready96),
    .outtie96(outtie96), .out_valid96(out_valid96), .out_ready96(out_ready96),
    .out_data96(out_data96), .out_index96(out_index96), .out_round96(out_round96),
    .level96(level96), .overflow96(overflow96));

  typedef struct { logic [31:0] data; logic [1:0] idx; logic [12:0] rnd; } word_t;
  typedef struct { logic [2:0][15:0] in; logic [31:0] e0, e1, e2; } vec_t;

  int    checks = 0, failures = 0;
  int    rnd_model = 0, done_rounds = 0, xfers = 0;
  word_t exp_q[$];
  word_t ew, prev_w;
  bit    prev_stall = 1'b0;
  vec_t  tbl[4];
  bit    pat[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference conversion from the IEEE field definitions (bias 15 -> bias 127).
  function automatic logic [31:0] ref_conv(input logic [15:0] h);
    int e;
    e = int'(h[14:10]);
    if (e == 0)  return {h[15], 31'b0};
    if (e == 31) return {h[15], 8'hFF, h[9:0], 13'b0};
    return {h[15], 8'(e - 15 + 127), h[9:0], 13'b0};
  endfunction

  task automatic push_exp(input logic [31:0] w0, w1, w2);
    exp_q.push_back('{w0, 2'd0, 13'(rnd_model)});
    exp_q.push_back('{w1, 2'd1, 13'(rnd_model)});
    exp_q.push_back('{w2, 2'd2, 13'(rnd_model)});
    rnd_model = (rnd_model + 1) % 8192;
  endtask

  task automatic push_ref(input logic [2:0][15:0] v);
    push_exp(ref_conv(v[0]), ref_conv(v[1]), ref_conv(v[2]));
  endtask

  function automatic logic [15:0] rand_h();
    logic [4:0] e;
    case ($urandom_range(0, 3))
      0:       e = 5'd0;
      1:       e = 5'd31;
      default: e = 5'($urandom_range(1, 30));
    endcase
    return {1'($urandom_range(0, 1)), e, 10'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk96); #1;
  endtask

  task automatic pulse(input logic [2:0][15:0] v);
    output_ready96 = 1'b1; outtie96 = v; tick();
    output_ready96 = 1'b0; tick();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid96 && n < 50) begin tick(); n++; end
    if (!out_valid96) begin
      checks++; failures++;
      $display("FAIL %s: out_valid96 never rose within %0d cycles", name, n);
    end
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid96 || level96 != 0) && n < maxc) begin tick(); n++; end
    if (n >= maxc) begin
      checks++; failures++;
      $display("FAIL %s: drain timeout, %0d words still expected", name, exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic reset_dut();
    rstn96 = 1'b0; tick(); rstn96 = 1'b1;
    exp_q.delete(); rnd_model = 0;
  endtask

  // Stream monitor: scoreboard on every handshake, stability while stalled.
  always @(negedge clk96) begin
    if (prev_stall) begin
      chk("stall_valid", out_valid96, 1'b1);
      chk("stall_word", {out_round96, out_index96, out_data96}, {prev_w.rnd, prev_w.idx, prev_w.data});
    end
    prev_stall = rstn96 && out_valid96 && !out_ready96;
    prev_w = '{out_data96, out_index96, out_round96};
    if (rstn96 && out_valid96 && out_ready96) begin
      xfers++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_xfer: got data=%h idx=%0d round=%0d with nothing expected",
                 out_data96, out_index96, out_round96);
      end else begin
        ew = exp_q.pop_front();
        chk("xfer_word", {out_round96, out_index96, out_data96}, {ew.rnd, ew.idx, ew.data});
      end
      if (out_index96 == 2'd2) done_rounds++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, issued;
    logic [2:0][15:0] v;

    tbl[0] = '{{16'h7E00, 16'hC000, 16'h3C00}, 32'h3F800000, 32'hC0000000, 32'h7FC00000};
    tbl[1] = '{{16'h7C00, 16'h8001, 16'h0001}, 32'h00000000, 32'h80000000, 32'h7F800000};
    tbl[2] = '{{16'hFC00, 16'h0400, 16'h7BFF}, 32'h477FE000, 32'h38800000, 32'hFF800000};
    tbl[3] = '{{16'h3555, 16'hBC00, 16'h8000}, 32'h80000000, 32'hBF800000, 32'h3EAAA000};
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset values
    tick(); tick();
    chk("rst_valid", out_valid96, 1'b0);
    chk("rst_data", out_data96, 32'h0);
    chk("rst_idx_round", {out_index96, out_round96}, 15'h0);
    chk("rst_level_ovf", {level96, overflow96}, 4'h0);
    rstn96 = 1'b1; tick();

    // Conversion table with capture-to-valid latency
    foreach (tbl[k]) begin
      push_exp(tbl[k].e0, tbl[k].e1, tbl[k].e2);
      out_ready96 = 1'b1; output_ready96 = 1'b1; outtie96 = tbl[k].in;
      @(posedge clk96); #1 output_ready96 = 1'b0;
      @(negedge clk96);
      chk("lat_level_N", level96, 3'd1);
      chk("lat_valid_N", out_valid96, 1'b0);
      @(negedge clk96);
      chk("lat_valid_N1", out_valid96, 1'b0);
      @(negedge clk96);
      chk("lat_valid_N2", {out_valid96, out_index96}, {1'b1, 2'd0});
      wait_drain("table", 50);
    end

    // Backpressure pattern 0,1,0,0,1,1
    out_ready96 = 1'b0;
    v = {16'h4000, 16'h3800, 16'hBC00};
    push_ref(v);
    output_ready96 = 1'b1; outtie96 = v; tick(); output_ready96 = 1'b0;
    wait_valid("bp_valid");
    base = xfers;
    for (int k = 0; k < 6; k++) begin out_ready96 = pat[k]; tick(); end
    out_ready96 = 1'b0;
    chk("bp_xfers", xfers - base, 3);
    chk("bp_valid_low", out_valid96, 1'b0);
    chk("bp_q_empty", exp_q.size(), 0);

    // Held strobe: 10 cycles high yields one round
    out_ready96 = 1'b1;
    v = {16'h4200, 16'hC400, 16'h3400};
    push_ref(v);
    base = done_rounds;
    output_ready96 = 1'b1; outtie96 = v; tick();
    chk("held_level", level96, 3'd1);
    repeat (9) tick();
    output_ready96 = 1'b0;
    wait_drain("held", 50);
    chk("held_rounds", done_rounds - base, 1);

    // Overflow: the first round moves to the hold register, so FIFO fills on the 5th
    // and the 6th is dropped.
    reset_dut();
    out_ready96 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      v = {16'h3C00 + 16'(k), 16'h4000 + 16'(k), 16'h4400 + 16'(k)};
      if (k < 5) push_ref(v);
      pulse(v);
      if (k == 4) chk("ovf_before_drop", {level96, overflow96}, {3'd4, 1'b0});
    end
    chk("ovf_level", level96, 3'd4);
    chk("ovf_flag", overflow96, 1'b1);
    out_ready96 = 1'b1;
    wait_drain("ovf_drain", 100);
    chk("ovf_sticky", overflow96, 1'b1);

    // Reset during SEND at idx1 with two rounds queued
    out_ready96 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v = {16'h5000 + 16'(k), 16'h5400 + 16'(k), 16'h5800 + 16'(k)};
      push_ref(v);
      pulse(v);
    end
    wait_valid("rst_mid_valid");
    out_ready96 = 1'b1; tick(); out_ready96 = 1'b0; tick();
    chk("rst_mid_pre", {out_valid96, out_index96, level96}, {1'b1, 2'd1, 3'd2});
    rstn96 = 1'b0; output_ready96 = 1'b1; outtie96 = {16'h1111, 16'h2222, 16'h3333};
    exp_q.delete(); rnd_model = 0;
    tick();
    output_ready96 = 1'b0;
    chk("rst_mid_valid", out_valid96, 1'b0);
    chk("rst_mid_data", out_data96, 32'h0);
    chk("rst_mid_idx_round", {out_index96, out_round96}, 15'h0);
    chk("rst_mid_level_ovf", {level96, overflow96}, 4'h0);
    rstn96 = 1'b1; tick();
    chk("rst_edge_no_capture", level96, 3'd0);
    out_ready96 = 1'b1;
    v = {16'h3A00, 16'hB800, 16'h4900};
    push_ref(v);
    pulse(v);
    wait_drain("rst_mid_new", 50);

    // Random traffic; never more rounds outstanding than the FIFO can hold
    base = done_rounds; issued = 0;
    for (int c = 0; c < 3000; c++) begin
      out_ready96 = ($urandom_range(0, 3) != 0);
      if (output_ready96) output_ready96 = 1'b0;
      else if ((issued - (done_rounds - base)) < DEPTH && $urandom_range(0, 2) == 0) begin
        v = {rand_h(), rand_h(), rand_h()};
        push_ref(v);
        outtie96 = v; output_ready96 = 1'b1; issued++;
      end else outtie96 = {rand_h(), rand_h(), rand_h()};
      tick();
    end
    output_ready96 = 1'b0; out_ready96 = 1'b1;
    wait_drain("rand_drain", 200);
    chk("rand_rounds", done_rounds - base, issued);
    chk("rand_no_ovf", overflow96, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
